// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD host command path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sd_cmd_pkg;

  // Serializer FSM states
  typedef enum logic [1:0] {
    PTS_IDLE = 2'd0,
    PTS_SEND = 2'd1,
    PTS_DONE = 2'd2
  } pts_state_t;

  // SD command frame length in bits
  localparam int SD_CMD_FRAME_W = 48;

  // Level driven on the CMD line when nothing is being sent
  localparam logic SD_CMD_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/pts_shift_reg.sv
// Loadable WIDTH-bit left shift register; msb is the bit that leaves next.
// Latency: load/shift take effect on the rising CLK edge.
// Backpressure: none; shifts whenever shift is high and load is low.
module pts_shift_reg #(
  parameter int WIDTH = 48
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q;

  // Load has priority over shift; zeros enter at the LSB
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/parallel_to_serial_tx.sv
// SD CMD serializer: captures a WIDTH-bit frame on start, sends it MSB first, then flags finished.
// Latency: first bit after the start edge, finished WIDTH edges after it; cleared one edge after start drops.
// Backpressure: none; optional macro PARALLEL_TO_SERIAL_ABORT_EN lets a low start_sending abort a frame in flight.
module parallel_to_serial_tx
  import sd_cmd_pkg::*;
#(
  parameter int WIDTH = SD_CMD_FRAME_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start_sending,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             finished,
  output logic             serial_out
);

  localparam int CW = $clog2(WIDTH);

  pts_state_t       state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             ser_nxt, fin_nxt;
  logic             load, shift, msb;
  logic [WIDTH-1:0] load_val;

  // The top bit goes straight to serial_out on the start edge, so the
  // register is loaded pre-shifted: its MSB is always the next bit to send.
  assign load_val = {parallel_in[WIDTH-2:0], 1'b0};

  pts_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (load),
    .shift (shift),
    .din   (load_val),
    .msb   (msb)
  );

  // State, counter and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= PTS_IDLE;
      cnt        <= '0;
      serial_out <= SD_CMD_IDLE_LEVEL;
      finished   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      serial_out <= ser_nxt;
      finished   <= fin_nxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ser_nxt   = serial_out;
    fin_nxt   = finished;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      PTS_IDLE: begin
        if (start_sending) begin
          state_nxt = PTS_SEND;
          load      = 1'b1;
          ser_nxt   = parallel_in[WIDTH-1];
          cnt_nxt   = CW'(WIDTH - 1);
          fin_nxt   = 1'b0;
        end
      end
      PTS_SEND: begin
`ifdef PARALLEL_TO_SERIAL_ABORT_EN
        if (!start_sending) begin
          state_nxt = PTS_IDLE;
          ser_nxt   = SD_CMD_IDLE_LEVEL;
          cnt_nxt   = '0;
          fin_nxt   = 1'b0;
        end else
`endif
        if (cnt != '0) begin
          shift   = 1'b1;
          ser_nxt = msb;
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = PTS_DONE;
          fin_nxt   = 1'b1;
          ser_nxt   = SD_CMD_IDLE_LEVEL;
        end
      end
      PTS_DONE: begin
        if (!start_sending) begin
          state_nxt = PTS_IDLE;
          fin_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = PTS_IDLE;
        ser_nxt   = SD_CMD_IDLE_LEVEL;
        fin_nxt   = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_parallel_to_serial_tx.sv
// Bench for parallel_to_serial_tx: frame table driven through a scoreboard queue,
// plus hand sequences for reset behaviour.
module tb_parallel_to_serial_tx;

  localparam int W = 48;
`ifdef PARALLEL_TO_SERIAL_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  logic         CLK;
  logic         RESET;
  logic         start_sending;
  logic [W-1:0] parallel_in;
  logic         finished;
  logic         serial_out;

  int tests;
  int failed;

  typedef struct packed {
    logic ser;
    logic fin;
  } exp_t;

  typedef struct {
    logic [W-1:0] frame;
    int           drop;  // first edge (E-index) that samples start_sending low
    int           chg;   // after this edge parallel_in is forced to all ones; -1 = never
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  parallel_to_serial_tx #(.WIDTH(W)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start_sending (start_sending),
    .parallel_in   (parallel_in),
    .finished      (finished),
    .serial_out    (serial_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, need finished");
    $fatal(1, "timeout");
  end

  function automatic void check(string nm, logic act, logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endfunction

  // Drives one frame starting at the current negedge; expected per-edge outputs
  // are queued up front and popped as each edge's result is sampled.
  task automatic run_frame(input int idx, input vec_t v);
    int   x;
    exp_t e;
    x = (v.drop > W) ? v.drop : W + 1;
    for (int k = 0; k <= x; k++) begin
      if (ABORT && v.drop <= W && k >= v.drop) e = '{ser: 1'b1, fin: 1'b0};
      else if (k < W)                          e = '{ser: v.frame[W-1-k], fin: 1'b0};
      else if (k < x)                          e = '{ser: 1'b1, fin: 1'b1};
      else                                     e = '{ser: 1'b1, fin: 1'b0};
      sb.push_back(e);
    end
    parallel_in   = v.frame;
    start_sending = 1'b1;
    for (int k = 0; k <= x; k++) begin
      @(negedge CLK);
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL v%0d scoreboard: got empty queue, expected entry for E%0d", idx, k);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d serial_out E%0d", idx, k), serial_out, e.ser);
        check($sformatf("v%0d finished E%0d", idx, k), finished, e.fin);
      end
      if (k + 1 == v.drop) start_sending = 1'b0;
      if (k == v.chg) parallel_in = {W{1'b1}};
    end
  endtask

  initial begin
    logic [W-1:0] rf;

    vecs[0] = '{frame: 48'hAAAB_AAAA_AAAF, drop: W + 3, chg: -1};
    vecs[1] = '{frame: 48'h0000_0000_0001, drop: W + 1, chg: -1};
    vecs[2] = '{frame: 48'h1234_5678_9ABC, drop: W + 1, chg: 5};
    vecs[3] = '{frame: 48'hC0FF_EE12_3456, drop: 20,    chg: -1};
    vecs[4] = '{frame: 48'hFFFF_FFFF_FFFE, drop: W + 1, chg: -1};
    vecs[5] = '{frame: 48'h8000_0000_0000, drop: W + 2, chg: -1};

    tests         = 0;
    failed        = 0;
    RESET         = 1'b1;
    start_sending = 1'b0;
    parallel_in   = '0;

    // Reset state before any clock edge
    #1;
    check("reset serial_out", serial_out, 1'b1);
    check("reset finished", finished, 1'b0);

    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("idle serial_out", serial_out, 1'b1);
    check("idle finished", finished, 1'b0);

    // Reset in the middle of a frame, after 10 bits have gone out
    rf            = 48'hF0F0_5A5A_3C3C;
    parallel_in   = rf;
    start_sending = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check($sformatf("rst-mid serial_out E%0d", k), serial_out, rf[W-1-k]);
    end
    #2;
    RESET = 1'b1;
    #1;
    check("rst-mid async serial_out", serial_out, 1'b1);
    check("rst-mid async finished", finished, 1'b0);
    start_sending = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check($sformatf("post-rst serial_out %0d", k), serial_out, 1'b1);
      check($sformatf("post-rst finished %0d", k), finished, 1'b0);
    end

    // Frame table; each frame starts right after the previous DONE->IDLE edge
    for (int i = 0; i < 6; i++) run_frame(i, vecs[i]);

    // Line stays idle afterwards
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      check($sformatf("tail serial_out %0d", k), serial_out, 1'b1);
      check($sformatf("tail finished %0d", k), finished, 1'b0);
    end

    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard drain: got %0d entries left, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
